// File: rtl/snake_move_ctl_pkg.sv
// Shared snake encodings, grid widths and default playfield bounds.
// The draw stages import the same package so that they agree on the playfield geometry.
package snake_pkg;

    localparam int X_W = 7;
    localparam int Y_W = 6;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Interior of the 40x20-grid frame at 16 px/grid, centred on 1024x768.
    localparam int DEF_X_MIN           = 13;
    localparam int DEF_X_MAX           = 50;
    localparam int DEF_Y_MIN           = 15;
    localparam int DEF_Y_MAX           = 32;
    localparam int DEF_START_X         = 31;
    localparam int DEF_START_Y         = 23;
    localparam int DEF_FRAMES_PER_MOVE = 8;

    // Opposite directions differ only in the LSB of the encoding.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_move_ctl_if.sv
// Button/vsync inputs and game-state outputs of the snake move controller.
interface snake_move_ctl_if;
    import snake_pkg::*;

    logic           vsync_in;
    logic           btn_up;
    logic           btn_down;
    logic           btn_left;
    logic           btn_right;
    logic           btn_start;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [1:0]     dir;
    logic [1:0]     state;
    logic           move_tick;
    logic           game_over;
    logic [15:0]    moves;

    modport master (
        output vsync_in, btn_up, btn_down, btn_left, btn_right, btn_start,
        input  head_x, head_y, dir, state, move_tick, game_over, moves
    );

    modport slave (
        input  vsync_in, btn_up, btn_down, btn_left, btn_right, btn_start,
        output head_x, head_y, dir, state, move_tick, game_over, moves
    );

endinterface

// File: rtl/snake_move_ctl_frame_tick_gen.sv
// Vsync rising-edge detector plus a frames-per-move divider.
// move_stb is high on the frame edge that completes a move period.
module frame_tick_gen #(
    parameter int FRAMES_PER_MOVE = 8
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic vsync_in,
    input  logic en,
    input  logic clr,
    output logic move_stb
);

    localparam int CNT_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_MOVE - 1);

    logic             vsync_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_edge;

    assign frame_edge = vsync_in & ~vsync_q;
    assign move_stb   = en & frame_edge & (frame_cnt == LAST);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_q <= vsync_in;
            if (clr) begin
                frame_cnt <= '0;
            end else if (en && frame_edge) begin
                frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_move_ctl.sv
// Snake game sequencer: head position, direction register, move scheduling
// and the IDLE/PLAY/OVER state machine. All outputs are registered.
module snake_move_ctl
    import snake_pkg::*;
#(
    parameter int X_MIN           = DEF_X_MIN,
    parameter int X_MAX           = DEF_X_MAX,
    parameter int Y_MIN           = DEF_Y_MIN,
    parameter int Y_MAX           = DEF_Y_MAX,
    parameter int START_X         = DEF_START_X,
    parameter int START_Y         = DEF_START_Y,
    parameter int FRAMES_PER_MOVE = DEF_FRAMES_PER_MOVE
) (
    input  logic              pclk,
    input  logic              rst_n,
    snake_move_ctl_if.slave   bus
);

    localparam logic [X_W-1:0] X_MIN_C   = X_W'(X_MIN);
    localparam logic [X_W-1:0] X_MAX_C   = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MIN_C   = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] Y_MAX_C   = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] START_X_C = X_W'(START_X);
    localparam logic [Y_W-1:0] START_Y_C = Y_W'(START_Y);

    state_t         state_r, state_nx;
    logic [X_W-1:0] head_x_r, head_x_nx;
    logic [Y_W-1:0] head_y_r, head_y_nx;
    dir_t           dir_r, dir_nx;
    dir_t           pend_r, pend_nx;
    logic [15:0]    moves_r, moves_nx;
    logic           move_tick_r, move_tick_nx;
    logic           game_over_r, game_over_nx;

    logic           move_stb;
    logic           btn_any;
    dir_t           cand;
    logic           in_bounds;
    logic [X_W-1:0] step_x;
    logic [Y_W-1:0] step_y;

    frame_tick_gen #(
        .FRAMES_PER_MOVE (FRAMES_PER_MOVE)
    ) u_frame_tick_gen (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .vsync_in (bus.vsync_in),
        .en       (state_r == ST_PLAY),
        .clr      (state_r != ST_PLAY),
        .move_stb (move_stb)
    );

    // Highest-priority pressed button; a dropped reversal never falls through.
    always_comb begin
        btn_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
        cand    = DIR_RIGHT;
        if (bus.btn_up) begin
            cand = DIR_UP;
        end else if (bus.btn_down) begin
            cand = DIR_DOWN;
        end else if (bus.btn_left) begin
            cand = DIR_LEFT;
        end
    end

    // Bounds are tested before stepping so the edges of the 7/6-bit range never wrap.
    always_comb begin
        step_x    = head_x_r;
        step_y    = head_y_r;
        in_bounds = 1'b0;
        case (pend_r)
            DIR_UP: begin
                in_bounds = (head_y_r > Y_MIN_C);
                step_y    = head_y_r - Y_W'(1);
            end
            DIR_DOWN: begin
                in_bounds = (head_y_r < Y_MAX_C);
                step_y    = head_y_r + Y_W'(1);
            end
            DIR_LEFT: begin
                in_bounds = (head_x_r > X_MIN_C);
                step_x    = head_x_r - X_W'(1);
            end
            default: begin
                in_bounds = (head_x_r < X_MAX_C);
                step_x    = head_x_r + X_W'(1);
            end
        endcase
    end

    always_comb begin
        state_nx     = state_r;
        head_x_nx    = head_x_r;
        head_y_nx    = head_y_r;
        dir_nx       = dir_r;
        pend_nx      = pend_r;
        moves_nx     = moves_r;
        move_tick_nx = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.btn_start) begin
                    state_nx = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (move_stb) begin
                    if (in_bounds) begin
                        head_x_nx    = step_x;
                        head_y_nx    = step_y;
                        dir_nx       = pend_r;
                        move_tick_nx = 1'b1;
                        moves_nx     = (moves_r == 16'hFFFF) ? moves_r : moves_r + 16'd1;
                    end else begin
                        state_nx = ST_OVER;
                    end
                end
                // Reversal is judged against the direction committed by this cycle.
                if (btn_any && (cand != reverse_dir(dir_nx))) begin
                    pend_nx = cand;
                end
            end
            ST_OVER: begin
                if (bus.btn_start) begin
                    state_nx  = ST_IDLE;
                    head_x_nx = START_X_C;
                    head_y_nx = START_Y_C;
                    dir_nx    = DIR_RIGHT;
                    pend_nx   = DIR_RIGHT;
                    moves_nx  = 16'd0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        game_over_nx = (state_nx == ST_OVER);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            head_x_r    <= START_X_C;
            head_y_r    <= START_Y_C;
            dir_r       <= DIR_RIGHT;
            pend_r      <= DIR_RIGHT;
            moves_r     <= 16'd0;
            move_tick_r <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            head_x_r    <= head_x_nx;
            head_y_r    <= head_y_nx;
            dir_r       <= dir_nx;
            pend_r      <= pend_nx;
            moves_r     <= moves_nx;
            move_tick_r <= move_tick_nx;
            game_over_r <= game_over_nx;
        end
    end

    assign bus.head_x    = head_x_r;
    assign bus.head_y    = head_y_r;
    assign bus.dir       = dir_r;
    assign bus.state     = state_r;
    assign bus.move_tick = move_tick_r;
    assign bus.game_over = game_over_r;
    assign bus.moves     = moves_r;

endmodule

// File: tb/tb_snake_move_ctl.sv
// Scoreboard bench for snake_move_ctl: directed game scenarios plus random play
// checked against a frame/move-level reference model.
module tb_snake_move_ctl;
    import snake_pkg::*;

    localparam int FPM  = 8;
    localparam int XMIN = 13;
    localparam int XMAX = 50;
    localparam int YMIN = 15;
    localparam int YMAX = 32;
    localparam int SX   = 31;
    localparam int SY   = 23;

    logic pclk  = 1'b0;
    logic rst_n = 1'b1;
    always #5 pclk = ~pclk;

    snake_move_ctl_if bus ();

    snake_move_ctl dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int kind;   // 0: move_tick, 1: state change
        int st;
        int x;
        int y;
        int d;
        int mv;
    } ev_t;

    ev_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int ticks = 0;

    logic b_up, b_down, b_left, b_right, b_start, b_vs, b_rstn;

    int m_state, m_x, m_y, m_d, m_pend, m_cnt, m_moves, m_vq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model_init();
        m_state = 0;
        m_x     = SX;
        m_y     = SY;
        m_d     = 3;
        m_pend  = 3;
        m_cnt   = 0;
        m_moves = 0;
    endfunction

    function automatic void push(input int kind);
        ev_t e;
        e.kind = kind;
        e.st   = m_state;
        e.x    = m_x;
        e.y    = m_y;
        e.d    = m_d;
        e.mv   = m_moves;
        exp_q.push_back(e);
    endfunction

    function automatic void model_move();
        int nx, ny;
        nx = m_x;
        ny = m_y;
        if (m_pend == 0) ny = m_y - 1;
        if (m_pend == 1) ny = m_y + 1;
        if (m_pend == 2) nx = m_x - 1;
        if (m_pend == 3) nx = m_x + 1;
        if (nx >= XMIN && nx <= XMAX && ny >= YMIN && ny <= YMAX) begin
            m_x     = nx;
            m_y     = ny;
            m_d     = m_pend;
            m_moves = (m_moves < 65535) ? m_moves + 1 : 65535;
            push(0);
        end else begin
            m_state = 2;
            push(1);
        end
    endfunction

    // One clock of game rules, using the inputs applied for this cycle.
    function automatic void model_step();
        bit fedge;
        int cand;
        fedge = b_vs && (m_vq == 0);
        m_vq  = b_vs;
        if (m_state == 0) begin
            if (b_start) begin
                m_state = 1;
                m_cnt   = 0;
                push(1);
            end
        end else if (m_state == 1) begin
            if (fedge) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == FPM) begin
                    m_cnt = 0;
                    model_move();
                end
            end
            cand = b_up ? 0 : b_down ? 1 : b_left ? 2 : b_right ? 3 : -1;
            if (cand >= 0) begin
                if (!((cand == 0 && m_d == 1) || (cand == 1 && m_d == 0) ||
                      (cand == 2 && m_d == 3) || (cand == 3 && m_d == 2)))
                    m_pend = cand;
            end
        end else begin
            if (b_start) begin
                model_init();
                push(1);
            end
        end
    endfunction

    task automatic cycle();
        @(negedge pclk);
        rst_n         = b_rstn;
        bus.vsync_in  = b_vs;
        bus.btn_up    = b_up;
        bus.btn_down  = b_down;
        bus.btn_left  = b_left;
        bus.btn_right = b_right;
        bus.btn_start = b_start;
        if (b_rstn) model_step();
    endtask

    task automatic frame(input logic dn_on_edge);
        logic saved;
        saved  = b_down;
        b_vs   = 1'b1;
        if (dn_on_edge) b_down = 1'b1;
        cycle();
        b_down = saved;
        b_vs   = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0);
    endtask

    task automatic press_start();
        b_start = 1'b1;
        cycle();
        b_start = 1'b0;
        cycle();
    endtask

    task automatic chk_head(input string nm, input int x, input int y);
        chk({nm, "_x"}, bus.head_x, x);
        chk({nm, "_y"}, bus.head_y, y);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_state"}, bus.state, 0);
        chk_head(nm, SX, SY);
        chk({nm, "_dir"}, bus.dir, 3);
        chk({nm, "_moves"}, bus.moves, 0);
        chk({nm, "_tick"}, bus.move_tick, 0);
        chk({nm, "_gameover"}, bus.game_over, 0);
    endtask

    // Monitor: every move_tick or state change must match the next expected event.
    logic [1:0] mon_last_state = 2'd0;
    always @(posedge pclk) begin
        ev_t e;
        #1;
        if (bus.move_tick === 1'b1) begin
            ticks++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_move_tick: head=(%0d,%0d), no move expected", bus.head_x, bus.head_y);
            end else begin
                e = exp_q.pop_front();
                chk("ev_kind_tick", 0, e.kind);
                chk_head("move_head", e.x, e.y);
                chk("move_dir", bus.dir, e.d);
                chk("move_moves", bus.moves, e.mv);
            end
        end
        if (bus.state !== mon_last_state) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_state_change: got %0d, expected %0d", bus.state, mon_last_state);
            end else begin
                e = exp_q.pop_front();
                chk("ev_kind_state", 1, e.kind);
                chk("state_val", bus.state, e.st);
                chk_head("state_head", e.x, e.y);
                chk("state_dir", bus.dir, e.d);
                chk("state_moves", bus.moves, e.mv);
                chk("state_gameover", bus.game_over, (e.st == 2) ? 1 : 0);
            end
        end
        mon_last_state = bus.state;
    end

    initial begin
        int t0;
        b_up = 0; b_down = 0; b_left = 0; b_right = 0; b_start = 0; b_vs = 0; b_rstn = 0;
        bus.vsync_in = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0;
        bus.btn_right = 0; bus.btn_start = 0;
        model_init();
        m_vq = 0;

        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (2) cycle();
        b_rstn = 1'b1;
        cycle();

        // Frame edges in IDLE must not move the head.
        t0 = ticks;
        frames(8);
        chk("idle_ticks", ticks - t0, 0);
        chk_head("idle", SX, SY);
        chk("idle_state", bus.state, 0);

        // Start and coast right: moves land on frames 8 and 16.
        press_start();
        t0 = ticks;
        frames(16);
        chk("coast_ticks", ticks - t0, 2);
        chk_head("coast", 33, 23);
        chk("coast_moves", bus.moves, 2);

        // Holding the reverse button is ignored; then turn up.
        b_left = 1'b1;
        frames(8);
        b_left = 1'b0;
        chk("rev_dir", bus.dir, 3);
        chk_head("rev", 34, 23);
        b_up = 1'b1;
        cycle();
        b_up = 1'b0;
        frames(8);
        chk_head("turn_up", 34, 22);
        chk("turn_up_dir", bus.dir, 0);
        chk("turn_up_moves", bus.moves, 4);

        // Priority and a press inside the move cycle.
        b_right = 1'b1;
        cycle();
        b_right = 1'b0;
        frames(8);
        chk_head("turn_right", 35, 22);
        b_up = 1'b1;
        b_left = 1'b1;
        cycle();
        b_up = 1'b0;
        b_left = 1'b0;
        frames(7);
        frame(1'b1);
        chk_head("prio_up", 35, 21);
        chk("prio_dir", bus.dir, 0);
        frames(8);
        chk_head("down_dropped", 35, 20);
        chk("down_dropped_dir", bus.dir, 0);
        chk("down_dropped_moves", bus.moves, 7);

        // Run into the right wall.
        b_right = 1'b1;
        cycle();
        b_right = 1'b0;
        frames(8 * 15);
        chk_head("at_wall", 50, 20);
        chk("at_wall_state", bus.state, 1);
        t0 = ticks;
        frames(8);
        chk("wall_ticks", ticks - t0, 0);
        chk_head("over", 50, 20);
        chk("over_state", bus.state, 2);
        chk("over_gameover", bus.game_over, 1);
        chk("over_moves", bus.moves, 22);
        frames(8);
        chk_head("over_frozen", 50, 20);
        press_start();
        chk_reset_vals("reinit");

        // Asynchronous reset on the cycle a move is due.
        press_start();
        frames(7);
        @(negedge pclk);
        bus.vsync_in = 1'b1;
        rst_n = 1'b0;
        b_rstn = 1'b0;
        if (m_state != 0) begin
            model_init();
            push(1);
        end
        model_init();
        m_vq = 0;
        #1 chk_reset_vals("midmove_reset");
        b_vs = 1'b0;
        repeat (3) cycle();
        b_rstn = 1'b1;
        t0 = ticks;
        frames(16);
        chk("post_reset_ticks", ticks - t0, 0);
        press_start();
        frames(8);
        chk("restart_ticks", ticks - t0, 1);
        chk_head("restart", 32, 23);

        // Random play against the reference model.
        for (int f = 0; f < 1200; f++) begin
            int gap;
            gap = $urandom_range(1, 4);
            for (int c = 0; c <= gap; c++) begin
                b_vs    = (c == 0);
                b_up    = ($urandom_range(0, 5) == 0);
                b_down  = ($urandom_range(0, 5) == 0);
                b_left  = ($urandom_range(0, 5) == 0);
                b_right = ($urandom_range(0, 5) == 0);
                b_start = ($urandom_range(0, 29) == 0);
                cycle();
            end
        end
        b_up = 0; b_down = 0; b_left = 0; b_right = 0; b_start = 0; b_vs = 0;
        repeat (3) cycle();
        chk("queue_drained", exp_q.size(), 0);
        chk("final_state", bus.state, m_state);
        chk_head("final", m_x, m_y);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
